// File: rtl/aqua_pkg.sv
// Shared definitions for the HC-SR04 front-end: state encodings, timing defaults
// and the 3-digit BCD increment helper.
package aqua_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'h0,
        ST_TRIGGER   = 4'h1,
        ST_WAIT_ECHO = 4'h2,
        ST_MEASURE   = 4'h3,
        ST_DONE      = 4'h4,
        ST_TIMEOUT   = 4'hF
    } estado_t;

    localparam int unsigned CLK_HZ             = 50_000_000;
    localparam int unsigned CM_TICKS_DEF       = 2941;
    localparam int unsigned HALF_TICK_DEF      = 1470;
    localparam int unsigned TRIGGER_CYCLES_DEF = 500;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 2_500_000;
    localparam int unsigned BCD_W              = 12;

    // Increment {hundreds, tens, units} with per-digit carry, holding at 999.
    function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == 12'h999) begin
            r = v;
        end else if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = v[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/contador_bcd_3dig.sv
// Three-digit BCD counter with synchronous clear and enable, saturating at 999.
module contador_bcd_3dig
    import aqua_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [11:0] count
);

    logic [11:0] count_r;

    // Count register: clear has priority over enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= 12'h000;
        end else if (clear) begin
            count_r <= 12'h000;
        end else if (enable) begin
            count_r <= bcd3_inc(count_r);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hcsr04_interface.sv
// HC-SR04 front-end: trigger pulse, echo width timing and conversion to BCD centimetres
// rounded to nearest, with a timeout guard on both echo waiting phases.
module hcsr04_interface
    import aqua_pkg::*;
#(
    parameter int unsigned TRIGGER_CYCLES = TRIGGER_CYCLES_DEF,
    parameter int unsigned CM_TICKS       = CM_TICKS_DEF,
    parameter int unsigned HALF_TICK      = HALF_TICK_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam logic [8:0]  TRIG_LAST = 9'(TRIGGER_CYCLES - 1);
    localparam logic [11:0] CM_LAST   = 12'(CM_TICKS - 1);
    localparam logic [11:0] HALF_PRE  = 12'(HALF_TICK);
    localparam logic [21:0] TO_LAST   = 22'(TIMEOUT_CYCLES - 1);

    estado_t     state_r, state_next_s;
    logic        echo_meta_r, echo_sync_r, echo_d_r;
    logic        rise_s, fall_s;
    logic [8:0]  trig_cnt_r;
    logic [21:0] to_cnt_r;
    logic [11:0] tick_r;
    logic        bcd_clear_s, bcd_en_s;
    logic [11:0] bcd_count_s;
    logic        trigger_r, pronto_r, erro_r;
    logic [11:0] medida_r;

    // Echo synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_meta_r <= 1'b0;
            echo_sync_r <= 1'b0;
            echo_d_r    <= 1'b0;
        end else begin
            echo_meta_r <= echo;
            echo_sync_r <= echo_meta_r;
            echo_d_r    <= echo_sync_r;
        end
    end

    assign rise_s = echo_sync_r & ~echo_d_r;
    assign fall_s = ~echo_sync_r & echo_d_r;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a rising echo wins over a simultaneous timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (medir) state_next_s = ST_TRIGGER;
                else       state_next_s = ST_IDLE;
            end
            ST_TRIGGER: begin
                if (trig_cnt_r == TRIG_LAST) state_next_s = ST_WAIT_ECHO;
                else                         state_next_s = ST_TRIGGER;
            end
            ST_WAIT_ECHO: begin
                if (rise_s)                   state_next_s = ST_MEASURE;
                else if (to_cnt_r == TO_LAST) state_next_s = ST_TIMEOUT;
                else                          state_next_s = ST_WAIT_ECHO;
            end
            ST_MEASURE: begin
                if (fall_s)                   state_next_s = ST_DONE;
                else if (to_cnt_r == TO_LAST) state_next_s = ST_TIMEOUT;
                else                          state_next_s = ST_MEASURE;
            end
            ST_DONE:    state_next_s = ST_IDLE;
            ST_TIMEOUT: state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // Trigger and timeout counters restart whenever their state is (re)entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trig_cnt_r <= 9'd0;
            to_cnt_r   <= 22'd0;
        end else begin
            if (state_r == ST_TRIGGER && state_next_s == ST_TRIGGER) trig_cnt_r <= trig_cnt_r + 9'd1;
            else                                                     trig_cnt_r <= 9'd0;
            if ((state_r == ST_WAIT_ECHO || state_r == ST_MEASURE) && state_next_s == state_r)
                to_cnt_r <= to_cnt_r + 22'd1;
            else
                to_cnt_r <= 22'd0;
        end
    end

    // Centimetre tick counter; the half-tick preload turns truncation into rounding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_r <= 12'd0;
        end else if (state_r == ST_WAIT_ECHO && rise_s) begin
            tick_r <= HALF_PRE;
        end else if (state_r == ST_MEASURE) begin
            tick_r <= (tick_r == CM_LAST) ? 12'd0 : tick_r + 12'd1;
        end else begin
            tick_r <= tick_r;
        end
    end

    assign bcd_clear_s = (state_r == ST_WAIT_ECHO) && rise_s;
    assign bcd_en_s    = (state_r == ST_MEASURE) && (tick_r == CM_LAST);

    contador_bcd_3dig u_bcd (
        .clock  (clock),
        .reset  (reset),
        .clear  (bcd_clear_s),
        .enable (bcd_en_s),
        .count  (bcd_count_s)
    );

    // Output registers; pronto, medida and erro update together on leaving DONE/TIMEOUT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trigger_r <= 1'b0;
            pronto_r  <= 1'b0;
            erro_r    <= 1'b0;
            medida_r  <= 12'h000;
        end else begin
            trigger_r <= (state_next_s == ST_TRIGGER);
            pronto_r  <= (state_r == ST_DONE) || (state_r == ST_TIMEOUT);
            if (state_r == ST_DONE) medida_r <= bcd_count_s;
            else                    medida_r <= medida_r;
            if (state_r == ST_TIMEOUT)              erro_r <= 1'b1;
            else if (state_r == ST_IDLE && medir)   erro_r <= 1'b0;
            else                                    erro_r <= erro_r;
        end
    end

    assign trigger   = trigger_r;
    assign pronto    = pronto_r;
    assign erro      = erro_r;
    assign medida    = medida_r;
    assign db_estado = state_r;

endmodule

// File: tb/tb_hcsr04_interface.sv
// Directed bench for hcsr04_interface using scaled timing (29 clocks per cm, short timeout).
module tb_hcsr04_interface;

    localparam int TRIG = 8;
    localparam int CMT  = 29;
    localparam int HALF = 14;
    localparam int TOUT = 4000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        medir = 1'b0;
    logic        echo  = 1'b0;
    logic        trigger, pronto, erro;
    logic [11:0] medida;
    logic [3:0]  db_estado;

    int checks = 0;
    int errors = 0;
    int pronto_pulses = 0;
    int trig_pulses = 0;
    logic trig_q = 1'b0;

    hcsr04_interface #(
        .TRIGGER_CYCLES (TRIG),
        .CM_TICKS       (CMT),
        .HALF_TICK      (HALF),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .medir     (medir),
        .echo      (echo),
        .trigger   (trigger),
        .medida    (medida),
        .pronto    (pronto),
        .erro      (erro),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (pronto) pronto_pulses <= pronto_pulses + 1;
        if (trigger && !trig_q) trig_pulses <= trig_pulses + 1;
        trig_q <= trigger;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start();
        @(negedge clock);
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
    endtask

    // Counts trigger-high samples; returns at the first low sample (WAIT_ECHO entry).
    task automatic trig_len(input bit spam, output int hi);
        int n;
        hi = 0;
        n = 0;
        while (trigger && n < 100) begin
            hi++;
            if (spam) medir = ~medir;
            @(negedge clock);
            n++;
        end
    endtask

    task automatic wait_pronto(input int bound, output int n);
        n = 0;
        while (!pronto && n < bound) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic measure(input int width, input logic [11:0] exp, input bit spam, input string tag);
        int hi, n, p0, t0;
        p0 = pronto_pulses;
        t0 = trig_pulses;
        start();
        check({tag, "_erro_clr"}, erro, 1'b0);
        trig_len(spam, hi);
        check({tag, "_trig_len"}, hi, TRIG);
        repeat (3) @(negedge clock);
        echo = 1'b1;
        for (int i = 0; i < width; i++) begin
            if (spam) medir = ~medir;
            @(negedge clock);
        end
        echo  = 1'b0;
        medir = 1'b0;
        wait_pronto(50, n);
        check({tag, "_pronto"}, pronto, 1'b1);
        check({tag, "_medida"}, medida, exp);
        check({tag, "_erro"}, erro, 1'b0);
        repeat (20) @(negedge clock);
        check({tag, "_npronto"}, pronto_pulses - p0, 1);
        check({tag, "_ntrig"}, trig_pulses - t0, 1);
        check({tag, "_idle"}, db_estado, 4'h0);
    endtask

    task automatic wait_timeout(input logic [11:0] keep, input string tag);
        int hi, n;
        start();
        trig_len(1'b0, hi);
        wait_pronto(TOUT + 100, n);
        check({tag, "_cycles"}, n, TOUT + 1);
        check({tag, "_pronto"}, pronto, 1'b1);
        check({tag, "_erro"}, erro, 1'b1);
        check({tag, "_medida"}, medida, keep);
        @(negedge clock);
        check({tag, "_pulse1"}, pronto, 1'b0);
        check({tag, "_erro_hold"}, erro, 1'b1);
    endtask

    initial begin
        int hi, n;

        repeat (3) @(negedge clock);
        check("rst_trigger", trigger, 1'b0);
        check("rst_medida", medida, 12'h000);
        check("rst_pronto", pronto, 1'b0);
        check("rst_erro", erro, 1'b0);
        check("rst_estado", db_estado, 4'h0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // (N + 14) / 29 rounded down
        measure(580,  12'h020, 1'b0, "m20");
        measure(2900, 12'h100, 1'b0, "m100a");
        measure(2914, 12'h100, 1'b0, "m100b");
        measure(2885, 12'h099, 1'b0, "m99_edge");
        measure(2886, 12'h100, 1'b0, "m100_edge");
        measure(14,   12'h000, 1'b0, "m0_edge");
        measure(15,   12'h001, 1'b0, "m1_edge");
        measure(2146, 12'h074, 1'b0, "m74");

        wait_timeout(12'h074, "to_noecho");
        measure(2146, 12'h074, 1'b1, "m74_spam");

        echo = 1'b1;
        repeat (5) @(negedge clock);
        wait_timeout(12'h074, "to_echo_pre");
        echo = 1'b0;
        repeat (5) @(negedge clock);

        // echo rises normally but never falls: timeout out of MEASURE
        start();
        trig_len(1'b0, hi);
        repeat (3) @(negedge clock);
        echo = 1'b1;
        wait_pronto(TOUT + 100, n);
        check("to_meas_pronto", pronto, 1'b1);
        check("to_meas_erro", erro, 1'b1);
        check("to_meas_medida", medida, 12'h074);
        echo = 1'b0;
        repeat (5) @(negedge clock);

        measure(580, 12'h020, 1'b0, "m20_b");

        // asynchronous reset in the middle of MEASURE
        start();
        trig_len(1'b0, hi);
        repeat (3) @(negedge clock);
        echo = 1'b1;
        repeat (100) @(negedge clock);
        check("pre_rst_estado", db_estado, 4'h3);
        #2 reset = 1'b0;
        #1;
        check("arst_trigger", trigger, 1'b0);
        check("arst_medida", medida, 12'h000);
        check("arst_estado", db_estado, 4'h0);
        check("arst_pronto", pronto, 1'b0);
        echo = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        measure(580, 12'h020, 1'b0, "m20_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
